// File: rtl/alu_issue_if.sv
// Command/result handshake bundle between instruction decode and alu_issue.
//   cmd_*  : one ALU command offered over valid/ready (decode -> alu_issue)
//   res_*  : result, zero flag and destination returned over valid/ready (alu_issue -> consumer)
// master = processor side, slave = alu_issue.
interface alu_issue_if #(
   parameter int unsigned N  = 8,
   parameter int unsigned AW = 2
);
   logic          cmd_valid;
   logic          cmd_ready;
   logic [1:0]    cmd_op;
   logic [AW-1:0] cmd_rd;
   logic [AW-1:0] cmd_rs1;
   logic [AW-1:0] cmd_rs2;
   logic          cmd_imm_en;
   logic [N-1:0]  cmd_imm;

   logic          res_valid;
   logic          res_ready;
   logic [N-1:0]  res_data;
   logic          res_zero;
   logic [AW-1:0] res_rd;

   modport master (
      output cmd_valid, cmd_op, cmd_rd, cmd_rs1, cmd_rs2, cmd_imm_en, cmd_imm, res_ready,
      input  cmd_ready, res_valid, res_data, res_zero, res_rd
   );

   modport slave (
      input  cmd_valid, cmd_op, cmd_rd, cmd_rs1, cmd_rs2, cmd_imm_en, cmd_imm, res_ready,
      output cmd_ready, res_valid, res_data, res_zero, res_rd
   );
endinterface

// File: rtl/alu_issue.sv
// Command sequencer in front of a combinational ALU. Accepts one command at a
// time, reads operands from a small register file (r0 reads zero), presents
// them to the ALU, writes the result back and returns it over a handshake.
// Ports:
//   clk, rstn        clock, asynchronous active-low reset
//   bus (slave)      cmd_* command handshake in, res_* result handshake out
//   alu_op, in1, in2 registered operands to the ALU (held outside EXEC)
//   alu_out, z       combinational result and zero flag from the ALU
//   dbg_addr/data    combinational register-file peek (index 0 reads 0)
module alu_issue #(
   parameter  int unsigned N        = 8,
   parameter  int unsigned RF_DEPTH = 4,
   localparam int unsigned AW       = $clog2(RF_DEPTH)
) (
   input  logic          clk,
   input  logic          rstn,
   alu_issue_if.slave    bus,
   output logic [1:0]    alu_op,
   output logic [N-1:0]  in1,
   output logic [N-1:0]  in2,
   input  logic [N-1:0]  alu_out,
   input  logic          z,
   input  logic [AW-1:0] dbg_addr,
   output logic [N-1:0]  dbg_data
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t        state;
   state_t        state_nxt;
   logic          accept_c;
   logic          res_done_c;
   logic [AW-1:0] rd_q;
   logic [N-1:0]  rf [RF_DEPTH];
   logic [N-1:0]  rs1_data_c;
   logic [N-1:0]  rs2_data_c;

   // Register-file read ports; r0 is hardwired to zero.
   assign rs1_data_c = (bus.cmd_rs1 == '0) ? '0 : rf[bus.cmd_rs1];
   assign rs2_data_c = (bus.cmd_rs2 == '0) ? '0 : rf[bus.cmd_rs2];
   assign dbg_data   = (dbg_addr    == '0) ? '0 : rf[dbg_addr];

   // State register.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next state and transfer strobes.
   always_comb begin
      state_nxt  = state;
      accept_c   = 1'b0;
      res_done_c = 1'b0;
      case (state)
         IDLE: begin
            if (bus.cmd_valid) begin
               accept_c  = 1'b1;
               state_nxt = EXEC;
            end
         end
         EXEC: begin
            state_nxt = RESP;
         end
         RESP: begin
            if (bus.res_ready) begin
               res_done_c = 1'b1;
               state_nxt  = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Operand capture, result capture and handshake outputs.
   // cmd_ready is a flop that tracks "next state is IDLE", so it always equals state==IDLE.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         bus.cmd_ready <= 1'b1;
         bus.res_valid <= 1'b0;
         bus.res_data  <= '0;
         bus.res_zero  <= 1'b0;
         bus.res_rd    <= '0;
         alu_op        <= '0;
         in1           <= '0;
         in2           <= '0;
         rd_q          <= '0;
      end else begin
         bus.cmd_ready <= (state_nxt == IDLE);
         if (accept_c) begin
            alu_op <= bus.cmd_op;
            in1    <= rs1_data_c;
            in2    <= bus.cmd_imm_en ? bus.cmd_imm : rs2_data_c;
            rd_q   <= bus.cmd_rd;
         end
         if (state == EXEC) begin
            bus.res_data  <= alu_out;
            bus.res_zero  <= z;
            bus.res_rd    <= rd_q;
            bus.res_valid <= 1'b1;
         end
         if (res_done_c) begin
            bus.res_valid <= 1'b0;
         end
      end
   end

   // Writeback in EXEC; completes before the next command can be accepted.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int i = 0; i < int'(RF_DEPTH); i++) begin
            rf[i] <= '0;
         end
      end else if ((state == EXEC) && (rd_q != '0)) begin
         rf[rd_q] <= alu_out;
      end
   end

endmodule

// File: tb/tb_alu_issue.sv
// Randomized and directed bench for alu_issue against a register-file model.
module tb_alu_issue;

   localparam int unsigned N     = 8;
   localparam int unsigned DEPTH = 4;
   localparam int unsigned AW    = 2;
   localparam int          MODV  = 1 << N;

   logic          clk = 1'b0;
   logic          rstn;
   logic [1:0]    alu_op;
   logic [N-1:0]  in1;
   logic [N-1:0]  in2;
   logic [N-1:0]  alu_out;
   logic          z;
   logic [AW-1:0] dbg_addr;
   logic [N-1:0]  dbg_data;

   int checks   = 0;
   int failures = 0;
   int mrf [DEPTH];

   always #5 clk = ~clk;

   alu_issue_if #(.N(N), .AW(AW)) bus ();

   alu_issue #(.N(N), .RF_DEPTH(DEPTH)) dut (
      .clk      (clk),
      .rstn     (rstn),
      .bus      (bus),
      .alu_op   (alu_op),
      .in1      (in1),
      .in2      (in2),
      .alu_out  (alu_out),
      .z        (z),
      .dbg_addr (dbg_addr),
      .dbg_data (dbg_data)
   );

   // Combinational ALU the block drives.
   always_comb begin
      case (alu_op)
         2'd0:    alu_out = in1 + in2;
         2'd1:    alu_out = in1 - in2;
         2'd2:    alu_out = in1 & in2;
         default: alu_out = in1 | in2;
      endcase
   end
   assign z = (alu_out == '0);

   function automatic int ref_alu(input int op, input int a, input int b);
      case (op)
         0:       return (a + b) % MODV;
         1:       return (a - b + MODV) % MODV;
         2:       return a & b;
         default: return a | b;
      endcase
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input int exp);
      checks++;
      if (got !== 32'(exp)) begin
         failures++;
         $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
      end
   endtask

   task automatic check_rf(input int idx);
      dbg_addr = AW'(idx);
      #1;
      check($sformatf("dbg_r%0d", idx), 32'(dbg_data), mrf[idx]);
   endtask

   task automatic check_lit(input int idx, input int exp);
      dbg_addr = AW'(idx);
      #1;
      check($sformatf("lit_r%0d", idx), 32'(dbg_data), exp);
   endtask

   task automatic apply_reset();
      rstn          = 1'b0;
      bus.cmd_valid = 1'b0;
      bus.res_ready = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rstn = 1'b1;
      foreach (mrf[i]) mrf[i] = 0;
      @(posedge clk);
      #1;
   endtask

   // One full command: accept, latency, optional backpressure, handshake, writeback.
   task automatic issue(input int op, input int rd, input int rs1, input int rs2,
                        input int imm_en, input int imm, input int stall);
      int  a, b, r;
      bit  acc;
      a = mrf[rs1];
      b = (imm_en != 0) ? imm : mrf[rs2];
      r = ref_alu(op, a, b);

      bus.cmd_op     = 2'(op);
      bus.cmd_rd     = AW'(rd);
      bus.cmd_rs1    = AW'(rs1);
      bus.cmd_rs2    = AW'(rs2);
      bus.cmd_imm_en = (imm_en != 0);
      bus.cmd_imm    = N'(imm);
      bus.cmd_valid  = 1'b1;
      bus.res_ready  = (stall == 0);

      acc = 1'b0;
      for (int i = 0; i < 20 && !acc; i++) begin
         acc = bus.cmd_ready;
         @(posedge clk);
         #1;
      end
      bus.cmd_valid = 1'b0;
      if (!acc) begin
         check("accept_timeout", 32'(0), 1);
         return;
      end

      check("busy_after_accept", 32'(bus.cmd_ready), 0);
      check("no_early_valid", 32'(bus.res_valid), 0);
      check("in1", 32'(in1), a);
      check("in2", 32'(in2), b);
      check("alu_op", 32'(alu_op), op);

      @(posedge clk);
      #1;
      check("res_valid_latency", 32'(bus.res_valid), 1);
      check("res_data", 32'(bus.res_data), r);
      check("res_zero", 32'(bus.res_zero), (r == 0) ? 1 : 0);
      check("res_rd", 32'(bus.res_rd), rd);

      if (stall > 0) begin
         // Offer a different command while the result is stalled; it must not be taken.
         bus.cmd_op     = 2'd0;
         bus.cmd_rd     = AW'(2);
         bus.cmd_rs1    = AW'(1);
         bus.cmd_imm_en = 1'b1;
         bus.cmd_imm    = N'(8'h77);
         bus.cmd_valid  = 1'b1;
         repeat (stall) begin
            @(posedge clk);
            #1;
            check("stall_valid", 32'(bus.res_valid), 1);
            check("stall_data", 32'(bus.res_data), r);
            check("stall_rd", 32'(bus.res_rd), rd);
            check("stall_cmd_ready", 32'(bus.cmd_ready), 0);
            check("stall_in1", 32'(in1), a);
            check("stall_in2", 32'(in2), b);
         end
         bus.res_ready = 1'b1;
      end

      @(posedge clk);
      #1;
      bus.cmd_valid = 1'b0;
      bus.res_ready = 1'b0;
      check("res_valid_clear", 32'(bus.res_valid), 0);
      check("ready_after_resp", 32'(bus.cmd_ready), 1);
      check("res_data_held", 32'(bus.res_data), r);
      if (rd != 0) mrf[rd] = r;
      check_rf(rd);
   endtask

   initial begin
      dbg_addr       = '0;
      bus.cmd_op     = '0;
      bus.cmd_rd     = '0;
      bus.cmd_rs1    = '0;
      bus.cmd_rs2    = '0;
      bus.cmd_imm_en = 1'b0;
      bus.cmd_imm    = '0;
      apply_reset();

      // Reset state
      check("rst_cmd_ready", 32'(bus.cmd_ready), 1);
      check("rst_res_valid", 32'(bus.res_valid), 0);
      check("rst_in1", 32'(in1), 0);
      check("rst_res_data", 32'(bus.res_data), 0);
      for (int i = 0; i < int'(DEPTH); i++) check_rf(i);

      // Dependent adds
      issue(0, 1, 0, 0, 1, 5, 0);
      issue(0, 2, 1, 0, 1, 10, 0);
      check_lit(2, 15);

      // SUB to zero, AND, OR
      issue(0, 1, 0, 0, 1, 30, 0);
      issue(1, 3, 1, 1, 0, 0, 0);
      check("sub_zero_flag", 32'(bus.res_zero), 1);
      issue(0, 1, 0, 0, 1, 51, 0);
      issue(2, 2, 1, 0, 1, 17, 0);
      check_lit(2, 17);
      issue(3, 2, 1, 0, 1, 12, 0);
      check_lit(2, 63);

      // rd=0 reports but does not write; wrap-around
      issue(0, 0, 1, 0, 1, 0, 0);
      check("rd0_res_data", 32'(bus.res_data), 51);
      check_lit(0, 0);
      issue(0, 1, 0, 0, 1, 200, 0);
      issue(0, 1, 1, 0, 1, 100, 0);
      check_lit(1, 44);

      // Backpressure, then the command that was offered during the stall
      issue(3, 3, 1, 2, 0, 0, 5);
      issue(0, 2, 1, 0, 1, 8'h77, 0);

      // Random commands
      for (int n = 0; n < 40; n++) begin
         issue(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
               int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
               int'($urandom_range(0, 1)), int'($urandom & 32'hFF),
               int'($urandom_range(0, 3)));
      end

      // Reset during EXEC drops the command
      bus.cmd_op     = 2'd0;
      bus.cmd_rd     = AW'(3);
      bus.cmd_rs1    = AW'(0);
      bus.cmd_imm_en = 1'b1;
      bus.cmd_imm    = N'(8'h5A);
      bus.cmd_valid  = 1'b1;
      bus.res_ready  = 1'b1;
      @(posedge clk);
      #1;
      bus.cmd_valid = 1'b0;
      check("exec_entered", 32'(bus.cmd_ready), 0);
      rstn = 1'b0;
      #1;
      check("async_rst_valid", 32'(bus.res_valid), 0);
      check("async_rst_ready", 32'(bus.cmd_ready), 1);
      @(posedge clk);
      @(negedge clk);
      rstn = 1'b1;
      foreach (mrf[i]) mrf[i] = 0;
      repeat (4) begin
         @(posedge clk);
         #1;
         check("post_rst_no_valid", 32'(bus.res_valid), 0);
      end
      check("post_rst_ready", 32'(bus.cmd_ready), 1);
      for (int i = 0; i < int'(DEPTH); i++) check_rf(i);

      // Block still works after the aborted command
      issue(0, 1, 0, 0, 1, 9, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
